multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-style control FSM that drives the multicycle RV32I datapath: PC, instruction/old-PC registers, shared instruction/data memory, register file, ALU and result muxes.
- Consumes opcode/funct fields from the instruction register and the ALU zero flag.
- Produces every enable and mux select the datapath requires, one microstep per clock.

Parameters:
- ILLEGAL_HALT, 1, 1 = unsupported opcode parks the FSM in TRAP until reset; 0 = unsupported opcode is treated as a NOP (returns to FETCH).
- CNT_WIDTH, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7_5  in  1  instruction[30]
- zero  in  1  ALU zero flag, combinational, same cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = result mux
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  enable for instruction and old-PC registers
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  2  0 = PC, 1 = OldPC, 2 = rs1 register
- ALUSrcB  out  2  0 = rs2 register, 1 = imm, 2 = constant 4
- ResultSrc  out  2  0 = ALUOut register, 1 = data register, 2 = ALU result
- ImmSel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
- ALUControl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASSB
- illegal  out  1  high while in TRAP

Behaviour:
- **Reset:**
  - reset = 0 forces the state to FETCH.
  - PCWrite, MemWrite, IRWrite and RegWrite are forced 0 while reset is low; illegal = 0.
  - The first rising edge after deassertion executes FETCH.
  - Reset asserted mid-instruction aborts the instruction immediately; no partial write is issued.
- **Outputs:** decoded from state only, except PCWrite in BRANCH and ImmSel/ALUControl in DECODE, EXECR and EXECI. Unlisted outputs are 0 / ADD.
- **FETCH:** AdrSrc = 0, IRWrite = 1, ALUSrcA = 0, ALUSrcB = 2, ADD, ResultSrc = 2, PCWrite = 1 -> DECODE.
- **DECODE:** ALUSrcA = 1, ALUSrcB = 1, ADD; computes the branch/jal target into ALUOut. ImmSel follows opcode. Next state:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - other -> TRAP if ILLEGAL_HALT = 1, else FETCH
- **MEMADR:** ALUSrcA = 2, ALUSrcB = 1, ADD, ImmSel = I for load and S for store -> MEMREAD (load) or MEMWRITE (store).
- **MEMREAD:** AdrSrc = 1, ResultSrc = 0 -> MEMWB.
- **MEMWB:** ResultSrc = 1, RegWrite = 1 -> FETCH.
- **MEMWRITE:** AdrSrc = 1, ResultSrc = 0, MemWrite = 1 -> FETCH.
- **EXECR:** ALUSrcA = 2, ALUSrcB = 0. ALUControl from funct3/funct7_5:
  - 000 -> ADD/SUB, selected by funct7_5
  - 001 -> SLL
  - 010 -> SLT
  - 011 -> SLTU
  - 100 -> XOR
  - 101 -> SRL/SRA, selected by funct7_5
  - 110 -> OR
  - 111 -> AND
  - Next -> ALUWB.
- **EXECI:** ALUSrcA = 2, ALUSrcB = 1, ImmSel = I. Same decode as EXECR, except funct3 = 000 is always ADD; funct7_5 is honoured only for 101. Next -> ALUWB.
- **ALUWB:** ResultSrc = 0, RegWrite = 1 -> FETCH.
- **JAL:** ALUSrcA = 1, ALUSrcB = 2, ADD, ResultSrc = 0, PCWrite = 1. PC takes the target held in ALUOut; ALUOut captures OldPC + 4. Next -> ALUWB.
- **BRANCH:** ALUSrcA = 2, ALUSrcB = 0, SUB, ResultSrc = 0.
  - funct3 = 000: PCWrite = zero.
  - funct3 = 001: PCWrite = !zero.
  - Other funct3: PCWrite = 0.
  - Next -> FETCH.
- **LUI:** ALUSrcB = 1, ImmSel = U, PASSB -> ALUWB.
- **TRAP:** all enables 0, illegal = 1, self-loop.
- **CPI:** load 5 cycles, store 4, R/I/LUI/JAL 4, branch 3.
- **State encoding:** 4-bit binary. Unreachable encodings return to FETCH on the next edge.

Optional Feature:
- Macro: MULTICYCLE_CTRL_INSTRET_EN.
- When defined:
  - Adds output instret [CNT_WIDTH-1:0], reset to 0.
  - instret increments by 1 on every edge that leaves MEMWB, MEMWRITE, ALUWB or BRANCH, and wraps at all-ones to 0.
  - Does not count illegal NOPs or TRAP cycles.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low for 3 cycles, then high -> all write enables 0 during reset; cycle 1 after release: IRWrite = 1, PCWrite = 1, ALUSrcB = 2.
- opcode = 0000011, funct3 = 010 (lw) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; AdrSrc = 1 in MEMREAD; RegWrite = 1 only in cycle 5; back to FETCH on cycle 6.
- opcode = 0110011, funct3 = 000, funct7_5 = 1 -> EXECR shows ALUControl = 1 (SUB); funct3 = 101, funct7_5 = 1 -> 7 (SRA).
- opcode = 1100011, funct3 = 001: zero = 1 -> PCWrite = 0 in BRANCH; zero = 0 -> PCWrite = 1; FETCH follows in both cases.
- opcode = 1111111 with ILLEGAL_HALT = 1 -> TRAP, illegal = 1 held for 20 cycles; reset pulse -> FETCH, illegal = 0. With ILLEGAL_HALT = 0 -> FETCH after DECODE, no writes.
- With MULTICYCLE_CTRL_INSTRET_EN and CNT_WIDTH = 4: 17 addi instructions -> instret = 1 after wrap; sw mid-sequence counts; a reset during MEMADR clears instret to 0 with MemWrite never asserted.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle RV32I datapath, one microstep per clock.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_control_unit #(
  parameter int unsigned ILLEGAL_HALT = 1
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  ,
  parameter int unsigned CNT_WIDTH    = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSel,
  output logic [3:0] ALUControl,
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  output logic [CNT_WIDTH-1:0] instret,
`endif
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  state_e state_q, state_d;
  logic   pc_we, mem_we, ir_we, rf_we;

  // Immediate forms never subtract: funct7_5 only distinguishes SRAI from SRLI.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_imm);
    case (f3)
      3'b000:  alu_dec = (f7 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_we      = 1'b0;
    AdrSrc     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    ImmSel     = IMM_I;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we     = 1'b1;
        pc_we     = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        case (opcode)
          OP_LOAD:   begin ImmSel = IMM_I; state_d = S_MEMADR; end
          OP_STORE:  begin ImmSel = IMM_S; state_d = S_MEMADR; end
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  begin ImmSel = IMM_I; state_d = S_EXECI; end
          OP_BRANCH: begin ImmSel = IMM_B; state_d = S_BRANCH; end
          OP_JAL:    begin ImmSel = IMM_J; state_d = S_JAL; end
          OP_LUI:    begin ImmSel = IMM_U; state_d = S_LUI; end
          default:   state_d = (ILLEGAL_HALT != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        if (opcode == OP_STORE) begin
          ImmSel  = IMM_S;
          state_d = S_MEMWRITE;
        end else begin
          ImmSel  = IMM_I;
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'd1;
        rf_we     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'd2;
        ALUControl = alu_dec(funct3, funct7_5, 1'b0);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        ALUControl = alu_dec(funct3, funct7_5, 1'b1);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'd2;
        ALUControl = ALU_SUB;
        case (funct3)
          3'b000:  pc_we = zero;
          3'b001:  pc_we = !zero;
          default: pc_we = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_LUI: begin
        ALUSrcB    = 2'd1;
        ImmSel     = IMM_U;
        ALUControl = ALU_PASSB;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // FETCH is held during reset, so its enables must be masked by reset itself.
  assign PCWrite  = pc_we  & reset;
  assign MemWrite = mem_we & reset;
  assign IRWrite  = ir_we  & reset;
  assign RegWrite = rf_we  & reset;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 retire;

  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BRANCH);

  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; a second instance
// with ILLEGAL_HALT = 0 covers the illegal-as-NOP path.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSel;
  logic [3:0] ALUControl;
  logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, illegal2;
  logic [1:0] ALUSrcA2, ALUSrcB2, ResultSrc2;
  logic [2:0] ImmSel2;
  logic [3:0] ALUControl2;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [3:0]  instret;
  logic [31:0] instret2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .ILLEGAL_HALT(1)
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , .CNT_WIDTH(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSel(ImmSel), .ALUControl(ALUControl),
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    .instret(instret),
`endif
    .illegal(illegal)
  );

  multicycle_control_unit #(
    .ILLEGAL_HALT(0)
  ) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .ResultSrc(ResultSrc2), .ImmSel(ImmSel2), .ALUControl(ALUControl2),
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    .instret(instret2),
`endif
    .illegal(illegal2)
  );

  logic [18:0] ob1, ob2;
  assign ob1 = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSel, ALUControl, illegal};
  assign ob2 = {PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, ALUSrcA2, ALUSrcB2,
                ResultSrc2, ImmSel2, ALUControl2, illegal2};

  function automatic logic [18:0] o(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] sa, sb, rs,
                                    input logic [2:0] imm, input logic [3:0] alu,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, sa, sb, rs, imm, alu, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: check the current microstep, then advance one clock.
  task automatic cyc(input string tag, input logic [18:0] e);
    #1 chk(tag, ob1, e);
    @(negedge clk);
  endtask

  logic [18:0] F, WB, DEC0, TRAPO;

  initial begin
    F     = o(1, 0, 0, 1, 0, 2'd0, 2'd2, 2'd2, 3'd0, 4'd0, 0);
    WB    = o(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0);
    DEC0  = o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd0, 4'd0, 0);
    TRAPO = o(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1);

    reset = 1'b0; opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("rst_enables", {PCWrite, MemWrite, IRWrite, RegWrite, illegal,
                             PCWrite2, MemWrite2, IRWrite2, RegWrite2, illegal2}, 32'd0);
    end
    reset = 1'b1;

    // lw
    cyc("lw_fetch", F);
    cyc("lw_decode", DEC0);
    cyc("lw_memadr", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 0));
    cyc("lw_memread", o(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
    cyc("lw_memwb", o(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd0, 4'd0, 0));

    // sub
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    cyc("sub_fetch", F);
    cyc("sub_decode", DEC0);
    cyc("sub_exec", o(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, 4'd1, 0));
    cyc("sub_wb", WB);

    // sra
    funct3 = 3'b101;
    cyc("sra_fetch", F);
    cyc("sra_decode", DEC0);
    cyc("sra_exec", o(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, 4'd7, 0));
    cyc("sra_wb", WB);

    // addi with bit30 set still adds
    opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1;
    cyc("addi_fetch", F);
    cyc("addi_decode", DEC0);
    cyc("addi_exec", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 0));
    cyc("addi_wb", WB);

    // srai / sltiu
    funct3 = 3'b101;
    cyc("srai_fetch", F);
    cyc("srai_decode", DEC0);
    cyc("srai_exec", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd7, 0));
    cyc("srai_wb", WB);
    funct3 = 3'b011; funct7_5 = 1'b0;
    cyc("sltiu_fetch", F);
    cyc("sltiu_decode", DEC0);
    cyc("sltiu_exec", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd9, 0));
    cyc("sltiu_wb", WB);

    // branches: bne taken/not-taken, beq taken, blt never writes PC
    opcode = 7'b1100011; funct3 = 3'b001; zero = 1'b1;
    cyc("bne_z1_fetch", F);
    cyc("bne_z1_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 0));
    cyc("bne_z1_branch", o(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, 4'd1, 0));
    zero = 1'b0;
    cyc("bne_z0_fetch", F);
    cyc("bne_z0_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 0));
    cyc("bne_z0_branch", o(1, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, 4'd1, 0));
    funct3 = 3'b000; zero = 1'b1;
    cyc("beq_fetch", F);
    cyc("beq_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 0));
    cyc("beq_branch", o(1, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, 4'd1, 0));
    funct3 = 3'b100;
    cyc("blt_fetch", F);
    cyc("blt_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 0));
    cyc("blt_branch", o(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, 4'd1, 0));
    zero = 1'b0;

    // sw
    opcode = 7'b0100011; funct3 = 3'b010;
    cyc("sw_fetch", F);
    cyc("sw_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    cyc("sw_memadr", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    cyc("sw_memwrite", o(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));

    // jal
    opcode = 7'b1101111;
    cyc("jal_fetch", F);
    cyc("jal_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd4, 4'd0, 0));
    cyc("jal_jal", o(1, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, 4'd0, 0));
    cyc("jal_wb", WB);

    // lui
    opcode = 7'b0110111;
    cyc("lui_fetch", F);
    cyc("lui_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd3, 4'd0, 0));
    cyc("lui_lui", o(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 3'd3, 4'd10, 0));
    cyc("lui_wb", WB);

    // illegal opcode: halting instance traps, NOP instance refetches
    opcode = 7'b1111111;
    cyc("ill_fetch", F);
    #1 chk("ill_nop_decode", ob2, DEC0);
    cyc("ill_decode", DEC0);
    for (int i = 0; i < 20; i++) begin
      #1 chk("ill_trap", ob1, TRAPO);
      chk("ill_nop_no_write", {MemWrite2, RegWrite2}, 32'd0);
      if (i == 0) chk("ill_nop_refetch", ob2, F);
      @(negedge clk);
    end
    reset = 1'b0;
    #1 chk("trap_rst_illegal", {illegal, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
    @(negedge clk);
    opcode = 7'b0100011; funct3 = 3'b010;
    reset = 1'b1;

    // reset during store MEMADR aborts without a memory write
    cyc("post_trap_fetch", F);
    cyc("abort_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    #1 chk("abort_memadr", ob1, o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    reset = 1'b0;
    #1 chk("abort_no_memwrite", {MemWrite, RegWrite}, 32'd0);
    @(negedge clk);
    #1 chk("abort_hold_no_memwrite", {MemWrite, PCWrite, IRWrite}, 32'd0);
    reset = 1'b1;
    cyc("abort_refetch", F);

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    chk("instret_after_abort", {28'd0, instret}, 32'd0);
    opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b0;
    cyc("cnt_first_decode", DEC0);
    cyc("cnt_first_exec", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 0));
    cyc("cnt_first_wb", WB);
    #1 chk("instret_1", {28'd0, instret}, 32'd1);
    for (int i = 1; i < 17; i++) begin
      repeat (4) @(negedge clk);
      #1 chk("instret_addi", {28'd0, instret}, (i + 1) % 16);
    end
    opcode = 7'b0100011; funct3 = 3'b010;
    cyc("cnt_sw_fetch", F);
    cyc("cnt_sw_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    cyc("cnt_sw_memadr", o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    cyc("cnt_sw_memwrite", o(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
    #1 chk("instret_sw", {28'd0, instret}, 32'd2);
    cyc("cnt_sw2_fetch", F);
    cyc("cnt_sw2_decode", o(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    #1 chk("cnt_sw2_memadr", ob1, o(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0, 0));
    reset = 1'b0;
    #1 chk("cnt_abort_no_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("instret_cleared", {28'd0, instret}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc("cnt_refetch", F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
